// File: rtl/regfile_pkg.sv
// Shared register-file types and sizing for the decode/operand-latch path.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Post-reset clear sequencer: walks every entry once, one per cycle, then idles in READY.
module regfile_clear_ctrl
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              busy_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  // One extra bit keeps the terminal count unambiguous against wrap-around.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(depth_of(ADDR_W) - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we_o = !rst_i;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign busy_o     = (state_q == CLEAR);
  assign clr_addr_o = cnt_q[ADDR_W-1:0];

endmodule

// File: rtl/regfile_sweep.sv
// Two-read/one-write register file with a post-reset clear sweep.
// Optional same-edge write-to-read bypass: define REGFILE_WR_BYPASS_EN.
module regfile_sweep
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              ren,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] writedata,
  input  logic              regwrite,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              rvalid,
  output logic              busy,
  output logic              wr_err
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              rvalid_q, rvalid_d;
  logic              wr_err_q, wr_err_d;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_en, wr_keep, rd_en;
  logic [DATA_W-1:0] rdata_a, rdata_b;

  regfile_clear_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clear_ctrl (
    .clk_i      (clk),
    .rst_i      (rst),
    .busy_o     (busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign wr_en   = regwrite && !busy && !rst;
  assign wr_keep = wr_en && !(ZERO_REG && (rd == '0));
  assign rd_en   = ren && !busy && !rst;

  always_comb begin
    rdata_a = mem_q[rs];
    rdata_b = mem_q[rt];
    if (ZERO_REG && (rs == '0)) rdata_a = '0;
    if (ZERO_REG && (rt == '0)) rdata_b = '0;
`ifdef REGFILE_WR_BYPASS_EN
    if (wr_keep && (rd == rs)) rdata_a = writedata;
    if (wr_keep && (rd == rt)) rdata_b = writedata;
`endif
  end

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    rvalid_d = 1'b0;
    wr_err_d = regwrite && busy;
    if (rd_en) begin
      a_d      = rdata_a;
      b_d      = rdata_b;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      rvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      rvalid_q <= rvalid_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Sweep and user writes never overlap: user writes are gated by busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_keep) begin
      mem_q[rd] <= writedata;
    end
  end

  assign A      = a_q;
  assign B      = b_q;
  assign rvalid = rvalid_q;
  assign wr_err = wr_err_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Directed self-checking bench for regfile_sweep (default parameters, ZERO_REG=1).
module tb_regfile_sweep;

  logic        clk;
  logic        rst;
  logic [4:0]  rs, rt, rd;
  logic        ren, regwrite;
  logic [31:0] writedata;
  logic [31:0] A, B;
  logic        rvalid, busy, wr_err;

  int unsigned errors;
  int unsigned checks;

`ifdef REGFILE_WR_BYPASS_EN
  localparam logic [31:0] HAZ_EXP = 32'h22;
`else
  localparam logic [31:0] HAZ_EXP = 32'h11;
`endif

  regfile_sweep #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rs        (rs),
    .rt        (rt),
    .ren       (ren),
    .rd        (rd),
    .writedata (writedata),
    .regwrite  (regwrite),
    .A         (A),
    .B         (B),
    .rvalid    (rvalid),
    .busy      (busy),
    .wr_err    (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren       = 1'b0;
    regwrite  = 1'b0;
    rs        = '0;
    rt        = '0;
    rd        = '0;
    writedata = '0;
  endtask

  int unsigned busy_cycles;

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle();

    // Reset held three cycles
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);

    // Sweep length after rst falls
    rst = 1'b0;
    busy_cycles = 0;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    check("sweep_len", busy_cycles, 32'd32);

    // Every entry reads zero after the sweep
    for (int i = 0; i < 32; i += 2) begin
      ren = 1'b1;
      rs  = 5'(i);
      rt  = 5'(i + 1);
      tick();
      check($sformatf("clr_A%0d", i), A, 32'd0);
      check($sformatf("clr_B%0d", i + 1), B, 32'd0);
    end
    check("clr_rvalid", 32'(rvalid), 32'd1);
    idle();

    // Write then read: one-cycle latency, rvalid drops, A holds
    regwrite  = 1'b1;
    rd        = 5'd5;
    writedata = 32'hDEADBEEF;
    tick();
    idle();
    ren = 1'b1;
    rs  = 5'd5;
    rt  = 5'd0;
    tick();
    check("lat_A", A, 32'hDEADBEEF);
    check("lat_B", B, 32'd0);
    check("lat_rvalid", 32'(rvalid), 32'd1);
    idle();
    tick();
    check("hold_rvalid", 32'(rvalid), 32'd0);
    check("hold_A", A, 32'hDEADBEEF);

    // Register 0 ignores writes and reads zero
    regwrite  = 1'b1;
    rd        = 5'd0;
    writedata = 32'h1234;
    tick();
    idle();
    ren = 1'b1;
    rs  = 5'd0;
    rt  = 5'd5;
    tick();
    check("zero_A", A, 32'd0);
    check("zero_B", B, 32'hDEADBEEF);
    check("zero_wr_err", 32'(wr_err), 32'd0);
    idle();

    // Same-edge read/write on one index, both ports on it
    regwrite  = 1'b1;
    rd        = 5'd9;
    writedata = 32'h11;
    tick();
    regwrite  = 1'b1;
    rd        = 5'd9;
    writedata = 32'h22;
    ren       = 1'b1;
    rs        = 5'd9;
    rt        = 5'd9;
    tick();
    check("haz_A", A, HAZ_EXP);
    check("haz_B", B, HAZ_EXP);
    idle();
    ren = 1'b1;
    rs  = 5'd9;
    rt  = 5'd5;
    tick();
    check("haz_after_A", A, 32'h22);
    check("haz_after_B", B, 32'hDEADBEEF);
    idle();

    // Reset pulse mid-operation, plus write/read attempts during the sweep
    regwrite  = 1'b1;
    rd        = 5'd3;
    writedata = 32'hA5;
    tick();
    idle();
    rst = 1'b1;
    tick();
    check("mid_busy", 32'(busy), 32'd1);
    check("mid_A", A, 32'd0);
    check("mid_rvalid", 32'(rvalid), 32'd0);
    rst = 1'b0;
    tick();
    regwrite  = 1'b1;
    rd        = 5'd7;
    writedata = 32'hFF;
    ren       = 1'b1;
    rs        = 5'd9;
    tick();
    check("busy_wr_err", 32'(wr_err), 32'd1);
    check("busy_rvalid", 32'(rvalid), 32'd0);
    check("busy_A_hold", A, 32'd0);
    idle();
    tick();
    check("busy_wr_err_end", 32'(wr_err), 32'd0);
    busy_cycles = 3;
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      tick();
    end
    check("mid_sweep_len", busy_cycles, 32'd32);
    ren = 1'b1;
    rs  = 5'd3;
    rt  = 5'd7;
    tick();
    check("mid_A3", A, 32'd0);
    check("mid_B7", B, 32'd0);
    check("mid_rvalid_rd", 32'(rvalid), 32'd1);
    idle();

    // Write while ready raises no error
    regwrite  = 1'b1;
    rd        = 5'd7;
    writedata = 32'h5A5A;
    tick();
    idle();
    check("ready_wr_err", 32'(wr_err), 32'd0);
    ren = 1'b1;
    rs  = 5'd7;
    rt  = 5'd3;
    tick();
    check("ready_A7", A, 32'h5A5A);
    check("ready_B3", B, 32'd0);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
